// File: rtl/snn_step_scheduler.sv
// snn_step_scheduler
//   Paces a spiking network one time-step at a time. A programmable divider
//   produces a tick every div_value+1 cycles. On each tick, if spike data is
//   ready, the scheduler latches the input spike vector and pulses step_start.
//   It then waits for step_done from the network, guarded by a watchdog.
//   Ticks that arrive while a step is still running are dropped and flagged.
//
// Ports
//   clk, reset_n         system clock, asynchronous active-low reset
//   clk_div_ready        SPI-side level: div_value valid (asynchronous)
//   input_spike_ready    SPI-side level: input_spikes valid (asynchronous)
//   div_value[7:0]       time-step period minus one, in clk cycles
//   input_spikes[7:0]    spike vector to launch with the next step
//   step_done            network pulse: current step evaluated
//   clear_err            clears the sticky error flags
//   step_start           one-cycle pulse: network begins a step
//   spikes_out[7:0]      spike vector latched for the current step
//   busy                 a step is being launched or is running
//   step_count[15:0]     completed steps, wraps
//   overrun              sticky: tick dropped because a step was in progress
//   timeout_err          sticky: step aborted by the watchdog
//
// state  | meaning
// IDLE   | divider not ready, waiting for rdy_s
// ARMED  | waiting for a tick with spike data ready
// LAUNCH | one cycle: step_start high, spikes_out just latched
// RUN    | waiting for step_done, watchdog running
module snn_step_scheduler #(
    parameter int STEP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_div_ready,
    input  logic        input_spike_ready,
    input  logic [7:0]  div_value,
    input  logic [7:0]  input_spikes,
    input  logic        step_done,
    input  logic        clear_err,
    output logic        step_start,
    output logic [7:0]  spikes_out,
    output logic        busy,
    output logic [15:0] step_count,
    output logic        overrun,
    output logic        timeout_err
);

    // The watchdog starts at 0 in LAUNCH, so the last RUN cycle before the
    // abort is the one where it reads STEP_TIMEOUT-1.
    localparam int WD_W = (STEP_TIMEOUT < 2) ? 1 : $clog2(STEP_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(STEP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARMED, LAUNCH, RUN} state_t;

    logic            rdy_m, rdy_s, spk_m, spk_s;
    logic [7:0]      tick_cnt;
    logic            tick;
    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic            step_active;
    logic            wd_expired;
    logic            set_timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
            spk_m <= 1'b0;
            spk_s <= 1'b0;
        end else begin
            rdy_m <= clk_div_ready;
            rdy_s <= rdy_m;
            spk_m <= input_spike_ready;
            spk_s <= spk_m;
        end
    end

    assign tick = rdy_s && (tick_cnt == div_value);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!rdy_s || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 8'd1;
        end
    end

    assign step_active = (state == LAUNCH) || (state == RUN);
    assign wd_expired  = (state == RUN) && (wd_cnt >= WD_LAST);
    // step_done in the expiry cycle still completes the step.
    assign set_timeout = rdy_s && wd_expired && !step_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            step_start  <= 1'b0;
            spikes_out  <= 8'h00;
            busy        <= 1'b0;
            step_count  <= 16'h0000;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Setting a flag takes priority over clearing it.
            overrun     <= (overrun && !clear_err) || (tick && step_active);
            timeout_err <= (timeout_err && !clear_err) || set_timeout;
            step_start  <= 1'b0;

            if (!rdy_s) begin
                // Divider went away: abandon any step, keep spikes_out.
                state  <= IDLE;
                busy   <= 1'b0;
                wd_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    ARMED: begin
                        if (tick && spk_s) begin
                            state      <= LAUNCH;
                            step_start <= 1'b1;
                            spikes_out <= input_spikes;
                            busy       <= 1'b1;
                            wd_cnt     <= '0;
                        end
                    end
                    LAUNCH: begin
                        state  <= RUN;
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    RUN: begin
                        if (step_done) begin
                            state      <= ARMED;
                            busy       <= 1'b0;
                            step_count <= step_count + 16'd1;
                        end else if (wd_expired) begin
                            state <= ARMED;
                            busy  <= 1'b0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
module tb_snn_step_scheduler;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_div_ready = 1'b0;
    logic        input_spike_ready = 1'b0;
    logic [7:0]  div_value = 8'd0;
    logic [7:0]  input_spikes = 8'd0;
    logic        step_done = 1'b0;
    logic        clear_err = 1'b0;
    logic        step_start;
    logic [7:0]  spikes_out;
    logic        busy;
    logic [15:0] step_count;
    logic        overrun;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int prints = 0;

    // network responder: step_done done_lat cycles after step_start (0 = never)
    int done_lat = 0;
    int done_cnt = 0;
    bit spurious = 1'b0;
    bit do_preload = 1'b0;

    // behavioural model
    bit [1:0]    m_rdy, m_spk;    // [1] is the synchronised view
    int          m_phase;         // cycles since last tick
    bit          m_on;            // divider seen ready, scheduling enabled
    bit          m_step;          // a step is launched and not finished
    int          m_age;           // cycles since step_start
    logic        e_start, e_busy, e_over, e_tout;
    logic [7:0]  e_spk;
    logic [15:0] e_cnt;

    always #5 clk = ~clk;

    snn_step_scheduler #(.STEP_TIMEOUT(TO)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .clk_div_ready     (clk_div_ready),
        .input_spike_ready (input_spike_ready),
        .div_value         (div_value),
        .input_spikes      (input_spikes),
        .step_done         (step_done),
        .clear_err         (clear_err),
        .step_start        (step_start),
        .spikes_out        (spikes_out),
        .busy              (busy),
        .step_count        (step_count),
        .overrun           (overrun),
        .timeout_err       (timeout_err)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
            end
        end
    endtask

    task automatic model_reset();
        m_rdy = 2'b00;
        m_spk = 2'b00;
        m_phase = 0;
        m_on = 1'b0;
        m_step = 1'b0;
        m_age = 0;
        e_start = 1'b0;
        e_busy = 1'b0;
        e_over = 1'b0;
        e_tout = 1'b0;
        e_spk = 8'h00;
        e_cnt = 16'h0000;
    endtask

    // Computes what the outputs must be after the coming rising edge,
    // from the inputs as they stand now.
    task automatic model_advance();
        bit rs, ss, tick, set_o, set_t;
        if (!reset_n) begin
            model_reset();
            return;
        end
        rs = m_rdy[1];
        ss = m_spk[1];
        tick = rs && (m_phase == int'(div_value));
        set_o = tick && m_step;
        set_t = 1'b0;
        if (!rs) begin
            m_on = 1'b0;
            m_step = 1'b0;
            e_start = 1'b0;
            e_busy = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1;
        end else if (!m_step) begin
            if (tick && ss) begin
                m_step = 1'b1;
                m_age = 0;
                e_start = 1'b1;
                e_busy = 1'b1;
                e_spk = input_spikes;
            end
        end else begin
            e_start = 1'b0;
            if (m_age >= 1 && step_done) begin
                m_step = 1'b0;
                e_busy = 1'b0;
                e_cnt = e_cnt + 16'd1;
            end else if (m_age >= TO - 1) begin
                m_step = 1'b0;
                e_busy = 1'b0;
                set_t = 1'b1;
            end
            m_age++;
        end
        e_over = (e_over && !clear_err) || set_o;
        e_tout = (e_tout && !clear_err) || set_t;
        m_phase = (!rs || m_phase == int'(div_value)) ? 0 : m_phase + 1;
        m_rdy = {m_rdy[0], clk_div_ready};
        m_spk = {m_spk[0], input_spike_ready};
    endtask

    // One clock cycle: compare at the falling edge, advance the model,
    // then return just after the rising edge where new inputs are driven.
    task automatic step();
        @(negedge clk);
        chk("step_start", 16'(step_start), 16'(e_start));
        chk("busy", 16'(busy), 16'(e_busy));
        chk("spikes_out", 16'(spikes_out), 16'(e_spk));
        chk("step_count", step_count, e_cnt);
        chk("overrun", 16'(overrun), 16'(e_over));
        chk("timeout_err", 16'(timeout_err), 16'(e_tout));
        if (do_preload) begin
            force dut.step_count = 16'hFFFF;
            #1 release dut.step_count;
            e_cnt = 16'hFFFF;
            do_preload = 1'b0;
        end
        model_advance();
        @(posedge clk);
        #1;
        if (step_start === 1'b1) begin
            done_cnt = done_lat;
            step_done = 1'b0;
        end else if (done_cnt > 0) begin
            done_cnt--;
            step_done = (done_cnt == 0);
        end else begin
            step_done = spurious && ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic rst_on();
        reset_n = 1'b0;
        model_reset();
    endtask

    task automatic wait_start(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (step_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("start_seen", 16'(seen), 16'd1);
    endtask

    initial begin
        int first, last, n, starts, busy_cycles;
        model_reset();
        repeat (3) step();
        chk("rst_step_start", 16'(step_start), 16'd0);
        chk("rst_spikes", 16'(spikes_out), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_count", step_count, 16'd0);
        chk("rst_overrun", 16'(overrun), 16'd0);
        chk("rst_timeout", 16'(timeout_err), 16'd0);
        reset_n = 1'b1;
        repeat (3) step();

        // steady stream: period 4, step_done 2 cycles after each start
        div_value = 8'd3;
        input_spikes = 8'hA5;
        done_lat = 2;
        clk_div_ready = 1'b1;
        input_spike_ready = 1'b1;
        first = -1;
        last = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (step_start === 1'b1) begin
                if (first < 0) first = k;
                else chk("start_period", 16'(k - last), 16'd4);
                last = k;
            end
        end
        chk("first_start", 16'(first), 16'd6);
        chk("stream_count", step_count, 16'd8);
        chk("stream_spikes", 16'(spikes_out), 16'h00A5);

        // no spike data: never launches
        rst_on();
        input_spike_ready = 1'b0;
        div_value = 8'd0;
        repeat (2) step();
        reset_n = 1'b1;
        starts = 0;
        busy_cycles = 0;
        repeat (100) begin
            step();
            if (step_start === 1'b1) starts++;
            if (busy === 1'b1) busy_cycles++;
        end
        chk("nospk_starts", 16'(starts), 16'd0);
        chk("nospk_busy", 16'(busy_cycles), 16'd0);
        chk("nospk_count", step_count, 16'd0);

        // overrun from ticks during long steps, then cleared
        rst_on();
        div_value = 8'd1;
        input_spike_ready = 1'b1;
        done_lat = 5;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (30) step();
        chk("overrun_set", 16'(overrun), 16'd1);
        input_spike_ready = 1'b0;
        repeat (12) step();
        chk("overrun_sticky", 16'(overrun), 16'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        step();
        chk("overrun_clr", 16'(overrun), 16'd0);
        chk("overrun_no_tout", 16'(timeout_err), 16'd0);

        // watchdog abort 8 cycles after step_start
        rst_on();
        div_value = 8'd0;
        input_spike_ready = 1'b1;
        input_spikes = 8'h5A;
        done_lat = 0;
        repeat (2) step();
        reset_n = 1'b1;
        wait_start(20);
        n = 0;
        while (n < 20 && timeout_err !== 1'b1) begin
            step();
            n++;
        end
        chk("timeout_lat", 16'(n), 16'd8);
        chk("timeout_busy", 16'(busy), 16'd0);
        chk("timeout_count", step_count, 16'd0);
        chk("timeout_spikes", 16'(spikes_out), 16'h005A);

        // step_done in the expiry cycle wins
        rst_on();
        done_lat = TO - 1;
        repeat (2) step();
        reset_n = 1'b1;
        wait_start(20);
        repeat (8) step();
        chk("coinc_count", step_count, 16'd1);
        chk("coinc_tout", 16'(timeout_err), 16'd0);
        chk("coinc_busy", 16'(busy), 16'd0);

        // step_count wrap
        input_spike_ready = 1'b0;
        repeat (14) step();
        do_preload = 1'b1;
        step();
        chk("preload", step_count, 16'hFFFF);
        done_lat = 2;
        input_spike_ready = 1'b1;
        wait_start(20);
        repeat (3) step();
        chk("wrap", step_count, 16'h0000);

        // divider ready dropped mid-RUN
        rst_on();
        done_lat = 0;
        input_spikes = 8'h3C;
        repeat (2) step();
        reset_n = 1'b1;
        wait_start(20);
        repeat (2) step();
        chk("abort_busy_before", 16'(busy), 16'd1);
        clk_div_ready = 1'b0;
        n = 0;
        while (n < 10 && busy === 1'b1) begin
            step();
            n++;
        end
        chk("abort_lat", 16'(n), 16'd3);
        chk("abort_count", step_count, 16'd0);
        chk("abort_spikes", 16'(spikes_out), 16'h003C);

        // reset pulse mid-RUN
        clk_div_ready = 1'b1;
        wait_start(20);
        repeat (2) step();
        rst_on();
        #2;
        chk("mrst_step_start", 16'(step_start), 16'd0);
        chk("mrst_spikes", 16'(spikes_out), 16'd0);
        chk("mrst_busy", 16'(busy), 16'd0);
        chk("mrst_count", step_count, 16'd0);
        chk("mrst_overrun", 16'(overrun), 16'd0);
        chk("mrst_timeout", 16'(timeout_err), 16'd0);
        step();
        reset_n = 1'b1;
        wait_start(20);

        // div_value 255: one tick every 256 cycles
        rst_on();
        div_value = 8'd255;
        done_lat = 1;
        repeat (2) step();
        reset_n = 1'b1;
        wait_start(300);
        n = 0;
        do begin
            step();
            n++;
        end while (n < 300 && step_start !== 1'b1);
        chk("div255_period", 16'(n), 16'd256);

        // randomized traffic against the model
        spurious = 1'b1;
        div_value = 8'd2;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) clk_div_ready = ~clk_div_ready;
            else if (!clk_div_ready && $urandom_range(0, 9) == 0) clk_div_ready = 1'b1;
            if ($urandom_range(0, 29) == 0) input_spike_ready = ~input_spike_ready;
            if ($urandom_range(0, 99) == 0) div_value = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) input_spikes = 8'($urandom);
            if ($urandom_range(0, 49) == 0) done_lat = int'($urandom_range(0, 10));
            clear_err = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) rst_on();
            else reset_n = 1'b1;
            step();
        end
        clear_err = 1'b0;
        reset_n = 1'b1;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snn_step_scheduler.md
SNN_STEP_SCHEDULER -- requirements
Module: snn_step_scheduler

Interface
REQ-001 SHALL have parameter STEP_TIMEOUT, default 255: max clk cycles in RUN without step_done before abort.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clk_div_ready  input  1  level from SPI block, asynchronous to clk; div_value valid while high.
REQ-005 SHALL have port input_spike_ready  input  1  level from SPI block, asynchronous to clk; input_spikes valid while high.
REQ-006 SHALL have port div_value  input  8  time-step period minus one, in clk cycles; quasi-static.
REQ-007 SHALL have port input_spikes  input  8  spike vector from SPI memory byte 0x00; quasi-static.
REQ-008 SHALL have port step_done  input  1  single-cycle pulse from network: time-step evaluation complete.
REQ-009 SHALL have port clear_err  input  1  synchronous clear of sticky error flags.
REQ-010 SHALL have port step_start  output  1  single-cycle pulse: network begins one time-step.
REQ-011 SHALL have port spikes_out  output  8  spike vector latched for current step.
REQ-012 SHALL have port busy  output  1  high in LAUNCH and RUN.
REQ-013 SHALL have port step_count  output  16  completed time-steps.
REQ-014 SHALL have port overrun  output  1  sticky: tick arrived while step in progress.
REQ-015 SHALL have port timeout_err  output  1  sticky: step aborted by watchdog.

Function
REQ-016 SHALL synchronise clk_div_ready and input_spike_ready with 2-flop synchronisers (rdy_s, spk_s); 2-cycle latency.
REQ-017 SHALL hold tick counter at 0 while rdy_s=0; else count 0..div_value, assert internal tick when count==div_value, wrap to 0 next cycle.
REQ-018 div_value=0 SHALL give tick every cycle; div_value=255 SHALL give tick every 256 cycles.
REQ-019 FSM states SHALL be IDLE, ARMED, LAUNCH, RUN.
REQ-020 IDLE -> ARMED when rdy_s=1.
REQ-021 ARMED: tick and spk_s=1 -> LAUNCH; tick and spk_s=0 -> stay ARMED, no step.
REQ-022 LAUNCH (one cycle): spikes_out <= input_spikes, step_start=1, watchdog cleared -> RUN.
REQ-023 RUN: step_done=1 -> ARMED, step_count+1 (wraps 0xFFFF->0x0000).
REQ-024 RUN: watchdog counts cycles; at STEP_TIMEOUT cycles without step_done -> timeout_err=1, ARMED, step_count unchanged.
REQ-025 step_done and watchdog expiry same cycle: step_done wins, no timeout_err.
REQ-026 tick in LAUNCH or RUN SHALL set overrun and be dropped (no queued step).
REQ-027 step_done outside RUN SHALL be ignored.
REQ-028 rdy_s falling in any state SHALL force IDLE next cycle, clear tick counter; aborted RUN does not increment step_count; spikes_out held.
REQ-029 clear_err=1 SHALL clear overrun and timeout_err; simultaneous set and clear: set wins.
REQ-030 step_start SHALL never be asserted in two consecutive cycles.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, synchronisers, tick and watchdog counters to 0, and step_start=0, spikes_out=0x00, busy=0, step_count=0x0000, overrun=0, timeout_err=0.
REQ-032 Reset asserted mid-RUN SHALL abort step without step_count change; after release FSM restarts from IDLE.

Verification
REQ-033 div_value=3, both readys high, input_spikes=0xA5, step_done 2 cycles after each step_start -> step_start every 4 cycles, spikes_out=0xA5, step_count 1,2,3...
REQ-034 input_spike_ready low, clk_div_ready high, div_value=0 -> no step_start for 100 cycles, busy=0, step_count=0.
REQ-035 div_value=1, step_done withheld 5 cycles -> overrun=1 after first dropped tick; clear_err pulse -> overrun=0.
REQ-036 STEP_TIMEOUT=8, step_done never -> timeout_err=1 exactly 8 cycles after step_start, FSM ARMED, step_count=0.
REQ-037 step_done coincident with watchdog expiry -> step_count=1, timeout_err=0; step_count at 0xFFFF + one step -> 0x0000.
REQ-038 clk_div_ready dropped mid-RUN -> IDLE within 3 cycles, busy=0, step_count unchanged; reset_n pulse mid-RUN -> all outputs zero.
